// File: rtl/mealy_machine_2bit.sv
// mealy_machine_2bit: overlapping serial detector for a 4-bit PATTERN, 2-bit state, Mealy output.
// Define MEALY_MACHINE_2BIT_REG_OUT_EN to register y (one-cycle-late, glitch-free).
module mealy_machine_2bit #(
    parameter logic [3:0] PATTERN = 4'b0101
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic y
);
    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    // Longest suffix of (matched prefix of length k, then b) that is a proper prefix of PATTERN.
    function automatic logic [1:0] nxt(input int k, input logic b);
        int h;
        h = (int'(PATTERN) >> (4 - k)) * 2 + int'(b);
        nxt = 2'd0;
        for (int l = 1; l <= 3; l++)
            if (l <= k + 1 && (h % (1 << l)) == (int'(PATTERN) >> (4 - l))) nxt = 2'(l);
    endfunction

    localparam logic [15:0] TBL = {nxt(3, 1'b1), nxt(3, 1'b0), nxt(2, 1'b1), nxt(2, 1'b0),
                                   nxt(1, 1'b1), nxt(1, 1'b0), nxt(0, 1'b1), nxt(0, 1'b0)};

    state_t state_q, state_d;
    logic   match;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state_q <= S0;
        else      state_q <= state_d;

    always_comb begin
        state_d = state_t'(TBL[{state_q, x, 1'b0} +: 2]);
        match   = (state_q == S3) && (x == PATTERN[0]);
    end

`ifdef MEALY_MACHINE_2BIT_REG_OUT_EN
    logic y_q;
    always_ff @(posedge clk or negedge rst)
        if (!rst) y_q <= 1'b0;
        else      y_q <= match;
    assign y = y_q;
`else
    assign y = match;
`endif
endmodule

// File: tb/tb_mealy_machine_2bit.sv
// tb_mealy_machine_2bit: table vectors, corner sequences and random streams vs a history-based model.
module tb_mealy_machine_2bit;
    localparam logic [3:0] P0 = 4'b0101;
    localparam logic [3:0] P1 = 4'b1111;

    logic clk = 1'b0, rst = 1'b0, x = 1'b0;
    logic y0, y1;
    always #5 clk = ~clk;

    mealy_machine_2bit #(.PATTERN(P0)) u0 (.clk(clk), .rst(rst), .x(x), .y(y0));
    mealy_machine_2bit #(.PATTERN(P1)) u1 (.clk(clk), .rst(rst), .x(x), .y(y1));

    typedef struct {
        logic       x;
        logic       y;
        logic [1:0] st;
    } vec_t;

    int checks = 0, failures = 0;
    int unsigned hist = 0;
    int cnt = 0;
    logic yr0 = 1'b0, yr1 = 1'b0;
    logic y0_pre, y0_post, y1_pre, y1_post;

    // Stream since reset kept as bits (newest in bit 0): match if the last four received bits equal p.
    function automatic logic mdl_y(logic [3:0] p, int unsigned h, int c, logic b);
        return c >= 3 && ((((h & 7) << 1) | int'(b)) == int'(p));
    endfunction

    function automatic int mdl_st(logic [3:0] p, int unsigned h, int c);
        for (int l = 3; l > 0; l--)
            if (l <= c && (h & ((1 << l) - 1)) == (int'(p) >> (4 - l))) return l;
        return 0;
    endfunction

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(logic b);
        logic e0, e1;
        @(negedge clk);
        x = b;
        #1;
        e0 = mdl_y(P0, hist, cnt, b);
        e1 = mdl_y(P1, hist, cnt, b);
        y0_pre = y0;
        y1_pre = y1;
`ifdef MEALY_MACHINE_2BIT_REG_OUT_EN
        chk("y0_before_edge", int'(y0), int'(yr0));
        chk("y1_before_edge", int'(y1), int'(yr1));
`else
        chk("y0_before_edge", int'(y0), int'(e0));
        chk("y1_before_edge", int'(y1), int'(e1));
`endif
        @(posedge clk);
        hist = (hist << 1) | int'(b);
        cnt++;
        yr0 = e0;
        yr1 = e1;
        #1;
        y0_post = y0;
        y1_post = y1;
        chk("state0", int'(u0.state_q), mdl_st(P0, hist, cnt));
        chk("state1", int'(u1.state_q), mdl_st(P1, hist, cnt));
    endtask

    // Asserts rst between edges, holds it with x toggling, releases just after a rising edge.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        hist = 0;
        cnt = 0;
        yr0 = 1'b0;
        yr1 = 1'b0;
        chk("rst_state0_now", int'(u0.state_q), 0);
        chk("rst_y0_now", int'(y0), 0);
        chk("rst_y1_now", int'(y1), 0);
        repeat (3) begin
            @(negedge clk);
            x = ~x;
            #1;
            chk("rst_hold_y0", int'(y0), 0);
            chk("rst_hold_y1", int'(y1), 0);
            @(posedge clk);
            #1;
            chk("rst_hold_state0", int'(u0.state_q), 0);
            chk("rst_hold_state1", int'(u1.state_q), 0);
        end
        rst = 1'b1;
    endtask

    vec_t tbl[14];
    int n;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 2'd1}; tbl[1]  = '{1'b1, 1'b0, 2'd2};
        tbl[2]  = '{1'b0, 1'b0, 2'd3}; tbl[3]  = '{1'b1, 1'b1, 2'd2};
        tbl[4]  = '{1'b0, 1'b0, 2'd3}; tbl[5]  = '{1'b1, 1'b1, 2'd2};
        tbl[6]  = '{1'b0, 1'b0, 2'd1}; tbl[7]  = '{1'b1, 1'b0, 2'd2};
        tbl[8]  = '{1'b1, 1'b0, 2'd0}; tbl[9]  = '{1'b0, 1'b0, 2'd1};
        tbl[10] = '{1'b0, 1'b0, 2'd1}; tbl[11] = '{1'b1, 1'b0, 2'd2};
        tbl[12] = '{1'b0, 1'b0, 2'd3}; tbl[13] = '{1'b0, 1'b0, 2'd1};

        #12;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (i == 6) do_reset();
            step(tbl[i].x);
`ifdef MEALY_MACHINE_2BIT_REG_OUT_EN
            chk($sformatf("tbl%0d_y", i), int'(y0_post), int'(tbl[i].y));
`else
            chk($sformatf("tbl%0d_y", i), int'(y0_pre), int'(tbl[i].y));
`endif
            chk($sformatf("tbl%0d_state", i), int'(u0.state_q), int'(tbl[i].st));
        end

        // Reach S3, present the matching bit, then reset between edges.
        do_reset();
        step(1'b0); step(1'b1); step(1'b0);
        @(negedge clk);
        x = 1'b1;
        #1;
`ifndef MEALY_MACHINE_2BIT_REG_OUT_EN
        chk("s3_match_present", int'(y0), 1);
`endif
        do_reset();
        n = 0;
        step(1'b1);
        foreach (tbl[i]) if (i < 4) begin
            step(tbl[i].x);
`ifdef MEALY_MACHINE_2BIT_REG_OUT_EN
            n += int'(y0_post);
`else
            n += int'(y0_pre);
`endif
        end
        chk("midrst_matches", n, 1);
        chk("midrst_last_y", int'(yr0), 1);

        // Degenerate all-ones pattern on the second instance.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
`ifdef MEALY_MACHINE_2BIT_REG_OUT_EN
            chk($sformatf("ones_bit%0d_y", i + 1), int'(y1_post), int'(i >= 3));
`else
            chk($sformatf("ones_bit%0d_y", i + 1), int'(y1_pre), int'(i >= 3));
`endif
            chk($sformatf("ones_bit%0d_state", i + 1), int'(u1.state_q), i >= 2 ? 3 : i + 1);
        end

        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(39) == 0) do_reset();
            step(1'($urandom_range(1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mealy_machine_2bit.md
# mealy_machine_2bit

Two-bit Mealy-type serial pattern detector. It watches a 1-bit input stream `x`, one bit per rising clock edge, and asserts `y` when the last four bits match a configurable 4-bit pattern. Overlapping matches are detected. It is a leaf control block in the FSM logic group and is used as a reference Mealy machine with a 2-bit state register.

## Interface
- `PATTERN`, default `4'b0101`: target sequence. `PATTERN[3]` is the oldest (first-received) bit and `PATTERN[0]` the newest.
- `clk`  input  1  system clock; all state updates occur on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `x`  input  1  serial data bit, sampled on each rising edge of `clk`.
- `y`  output  1  match flag.

## Operation
- State register: 2 bits, encoding the number of pattern bits currently matched.
  - S0=`2'b00`: nothing matched.
  - S1=`2'b01`: `PATTERN[3]` matched.
  - S2=`2'b10`: `PATTERN[3:2]` matched.
  - S3=`2'b11`: `PATTERN[3:1]` matched.
- Next state: let `h` be the matched prefix followed by `x`. The next state is the length of the longest suffix of `h` that is also a proper prefix of `PATTERN`, capped at 3.
  - Computed at elaboration from `PATTERN`, by function or generate.
  - Must be correct for all 16 values of `PATTERN`.
- Output: `y = (state == S3) && (x == PATTERN[0])`. This is combinational from the state and the current `x` (Mealy output).
- On a full match, the next state is the overlap length, not S0.
- Default transitions (`0101`):
  - S0: x0 goes to S1; x1 goes to S0.
  - S1: x0 goes to S1; x1 goes to S2.
  - S2: x0 goes to S3; x1 goes to S0.
  - S3: x1 goes to S2 with y=1; x0 goes to S1.
- Degenerate patterns: for `0000` and `1111`, S3 self-loops on a match, so `y` stays high for a continuous run.
- No illegal states exist; all four encodings are reachable or benign.

## Timing
- `rst` low: the state goes to S0 immediately (asynchronous), and `y` is forced to 0 regardless of `x`.
- `rst` deassertion: the first rising edge with `rst` high samples `x`. The system must deassert `rst` synchronously to `clk`.
- Reset asserted mid-sequence: partial match progress is discarded, and the first bit after reset is treated as a fresh stream start.
- Latency, combinational `y`: `y` rises in the same cycle the fourth matching bit is presented, before the capturing edge. It stays valid until `x` or the state changes.
- `x` must be stable around each rising edge (setup/hold). `y` may glitch while `x` is changing mid-cycle.

## Configuration
- `MEALY_MACHINE_2BIT_REG_OUT_EN` defined:
  - `y` is driven from a flip-flop loaded on each rising edge with the Mealy value `(state==S3 && x==PATTERN[0])`.
  - `y` is therefore asserted for one cycle, starting one clock after the matching bit is captured, and is glitch-free.
  - The flip-flop clears asynchronously to 0 while `rst` is low.
- Undefined (default): `y` is the purely combinational Mealy output described above.

## Test plan
- Reset: hold `rst`=0 with `x` toggling → `y`=0 and state=S0 throughout. Release with `x`=0; the first edge moves the state to S1.
- Basic match, default `PATTERN`: x=0,1,0,1 on successive edges.
  - Combinational: `y`=1 while the 4th bit (1) is presented in S3.
  - REG_OUT: `y`=1 for exactly the cycle after that edge.
- Overlap: stream 0,1,0,1,0,1 → two `y` pulses, on bits 4 and 6. The state after each match is S2.
- Near misses: stream 0,1,1,0,0,1,0,0 → `y` never asserts. The states follow S1,S2,S0,S1,S1,S2,S3,S1.
- Async reset mid-match: reach S3, then pulse `rst` low between edges → state=S0 and `y`=0 immediately. The next bits 1 then 0,1,0,1 → exactly one match, on the final bit.
- Alternate parameter `PATTERN`=`4'b1111`: x=1 held for 6 edges → `y` first asserts on bit 4 and stays high through bit 6.
